alu_seq: RTL
============

Name: alu_seq

Overview:
Parametrised multi-cycle ALU for the RCPU datapath. It keeps the 4-bit function encoding used by the core and adds a start/busy/done handshake with registered results. Multiply becomes an iterative N-cycle signed shift-add, and a new N-cycle unsigned restoring divide takes opcode 0110. Shift/rotate widths scale with N.

Parameters:
N, 16, datapath width (power of two, >= 8)
SW, $clog2(N), shift-amount width; shift count is b[SW-1:0]

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
a  in  N  operand A
b  in  N  operand B
func  in  4  operation select
ci  in  1  carry/borrow in
busy  out  1  multi-cycle op in progress
done  out  1  one-cycle pulse; results valid
y  out  N  primary result (low product, quotient)
hi  out  N  high product / remainder; 0 for other ops
co  out  1  carry/borrow/shifted-out bit
zero  out  1  y==0 && hi==0
overflow  out  1  signed overflow / div-by-zero
negative  out  1  hi==0 ? y[N-1] : hi[N-1]
div_by_zero  out  1  set with divide, b==0

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, done, y, hi, co, zero, overflow and negative all go to 0. Internal accumulators clear.
- Handshake: on a clk edge with start=1 and busy=0, capture a, b, func and ci.
  - start while busy=1 is ignored; no queueing.
- Results stay held after done until the next accepted op. They change only at that op's done edge.
- Single-cycle ops: results register on the accepting edge. done=1 for exactly the next cycle; busy stays 0.
- Multi-cycle ops (0100, 0101, 0110 with b!=0):
  - busy=1 from the accepting edge for N cycles.
  - On the Nth edge: results load, busy=0, done=1.
  - A new start is legal in the done cycle.
- FSM: IDLE -> MUL (0100/0101) or DIV (0110, b!=0); other ops stay in IDLE. An N-step counter runs in MUL and DIV; each returns to IDLE at count N-1.
- Add/sub group:
  - 0000 add: y=a+b. 0001 adc: y=a+b+ci.
  - 0010 sub: y=a-b. 0011 sbc: y=a-b-ci.
  - co: carry out for add; 1 on borrow for sub.
  - overflow: standard signed overflow.
- 0100/0101 signed multiply: {hi,y} = 2N-bit two's-complement product.
  - Implementation: iterate on magnitudes, negate the result at the end when signs differ.
  - overflow=1 only for 0101, and only when hi is not the sign extension of y[N-1].
  - co=0.
- 0110 unsigned divide: y=a/b, hi=a%b.
  - b==0: single-cycle. y=all ones, hi=a, overflow=1, div_by_zero=1.
- 0111 arithmetic shift right by s=b[SW-1:0]: y=a>>>s. co = last bit shifted out (0 when s=0).
- 1000 shl: y=a<<s, co = last bit out of MSB (0 if s=0).
- 1001 shr (logical): y=a>>s, co = last bit out of LSB (0 if s=0).
- 1010 rol / 1011 ror by s: co=0.
- 1100 and, 1101 or, 1110 xor, 1111 not-a: co=0, overflow=0.
- hi=0 for every op except multiply and divide. div_by_zero=0 for every op except divide-by-zero.
- Flags register together with y/hi. zero and negative follow the formulas in Ports.
- Reset mid-operation aborts the op: no done pulse, outputs return to 0.

Test Plan:
- N=16, add 0000 a=7FFF b=0001 -> one cycle later done=1, y=8000, overflow=1, co=0, negative=1, busy never high.
- sub 0010 a=0000 b=0001 -> y=FFFF, co=1, negative=1; sbc 0011 a=0005 b=0002 ci=1 -> y=0002, co=0.
- mul 0101 a=0100 b=0100 -> busy 16 cycles, done exactly 16 cycles after accept; hi=0001, y=0000, overflow=1, zero=0. Extra start pulses while busy have no effect.
- mul 0100 a=FFFE b=0003 -> y=FFFA, hi=FFFF, overflow=0, negative=1; back-to-back start in done cycle accepted.
- div 0110 a=0064 b=0007 -> after 16 cycles y=000E, hi=0002. b=0000 -> done next cycle, y=FFFF, hi=0064, div_by_zero=1, overflow=1.
- asr 0111 a=8003 b=0001 -> y=C001, co=1; rol 1010 a=8001 b=0004 -> y=0018; assert rst_n=0 at cycle 5 of a mul -> busy=0, no done, all outputs 0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake, iterative signed multiply
// and restoring unsigned divide; all results and flags are registered.
module alu_seq #(
  parameter int N  = 16,
  parameter int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   func,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] y,
  output logic [N-1:0] hi,
  output logic         co,
  output logic         zero,
  output logic         overflow,
  output logic         negative,
  output logic         div_by_zero
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0] p_q, p_d;
  logic [N-1:0] m_q, m_d;
  logic sgn_q, sgn_d, mx_q, mx_d;
  logic [N-1:0] y_q, y_d, hi_q, hi_d;
  logic co_q, co_d, zero_q, zero_d, ovf_q, ovf_d, neg_q, neg_d, dbz_q, dbz_d, done_q, done_d;
  logic load;
  logic [N-1:0] ry, rh, ma, mb;
  logic rco, rovf, rdbz;
  logic [N:0] sum, ss, rsh, rdf;
  logic [2*N-1:0] rol2, ror2, pm, pd, prod;
  logic [SW-1:0] sh, sm1, ns;
  always_comb begin
    ma   = a[N-1] ? -a : a;
    mb   = b[N-1] ? -b : b;
    sh   = b[SW-1:0];
    sm1  = sh - 1'b1;
    ns   = ~sh + 1'b1;
    sum  = func[1] ? {1'b0, a} - {1'b0, b} - {{N{1'b0}}, func[0] & ci}
                   : {1'b0, a} + {1'b0, b} + {{N{1'b0}}, func[0] & ci};
    rol2 = {a, a} << sh;
    ror2 = {a, a} >> sh;
    // one shift-add step on magnitudes; {hi,lo} shifts right, lo starts as |b|
    ss   = {1'b0, p_q[2*N-1:N]} + (p_q[0] ? {1'b0, m_q} : '0);
    pm   = {ss, p_q[N-1:1]};
    prod = sgn_q ? -pm : pm;
    // one restoring-divide step: {rem,quot} shifts left, quotient bits enter at LSB
    rsh  = {p_q[2*N-1:N], p_q[N-1]};
    rdf  = rsh - {1'b0, m_q};
    pd   = {rdf[N] ? rsh[N-1:0] : rdf[N-1:0], p_q[N-2:0], ~rdf[N]};
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    m_d     = m_q;
    sgn_d   = sgn_q;
    mx_d    = mx_q;
    load    = 1'b0;
    ry      = '0;
    rh      = '0;
    rco     = 1'b0;
    rovf    = 1'b0;
    rdbz    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (func == 4'b0100 || func == 4'b0101) begin
          state_d = MUL;
          cnt_d   = '0;
          p_d     = {{N{1'b0}}, mb};
          m_d     = ma;
          sgn_d   = a[N-1] ^ b[N-1];
          mx_d    = func[0];
        end else if (func == 4'b0110 && b != '0) begin
          state_d = DIV;
          cnt_d   = '0;
          p_d     = {{N{1'b0}}, a};
          m_d     = b;
        end else begin
          load = 1'b1;
          case (func)
            4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
              ry   = sum[N-1:0];
              rco  = sum[N];
              rovf = (func[1] ? a[N-1] != b[N-1] : a[N-1] == b[N-1]) && sum[N-1] != a[N-1];
            end
            4'b0110: begin
              ry   = '1;
              rh   = a;
              rovf = 1'b1;
              rdbz = 1'b1;
            end
            4'b0111: begin
              ry  = $signed(a) >>> sh;
              rco = sh != '0 && a[sm1];
            end
            4'b1000: begin
              ry  = a << sh;
              rco = sh != '0 && a[ns];
            end
            4'b1001: begin
              ry  = a >> sh;
              rco = sh != '0 && a[sm1];
            end
            4'b1010: ry = rol2[2*N-1:N];
            4'b1011: ry = ror2[N-1:0];
            4'b1100: ry = a & b;
            4'b1101: ry = a | b;
            4'b1110: ry = a ^ b;
            4'b1111: ry = ~a;
            default: ry = '0;
          endcase
        end
      end
      MUL: begin
        p_d   = pm;
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = IDLE;
          load    = 1'b1;
          ry      = prod[N-1:0];
          rh      = prod[2*N-1:N];
          rovf    = mx_q && prod[2*N-1:N] != {N{prod[N-1]}};
        end
      end
      DIV: begin
        p_d   = pd;
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = IDLE;
          load    = 1'b1;
          ry      = pd[N-1:0];
          rh      = pd[2*N-1:N];
        end
      end
      default: state_d = IDLE;
    endcase
    y_d    = load ? ry : y_q;
    hi_d   = load ? rh : hi_q;
    co_d   = load ? rco : co_q;
    ovf_d  = load ? rovf : ovf_q;
    dbz_d  = load ? rdbz : dbz_q;
    zero_d = load ? (ry == '0 && rh == '0) : zero_q;
    neg_d  = load ? (rh == '0 ? ry[N-1] : rh[N-1]) : neg_q;
    done_d = load;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      sgn_q   <= 1'b0;
      mx_q    <= 1'b0;
      y_q     <= '0;
      hi_q    <= '0;
      co_q    <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      m_q     <= m_d;
      sgn_q   <= sgn_d;
      mx_q    <= mx_d;
      y_q     <= y_d;
      hi_q    <= hi_d;
      co_q    <= co_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end
  assign busy        = state_q != IDLE;
  assign done        = done_q;
  assign y           = y_q;
  assign hi          = hi_q;
  assign co          = co_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign negative    = neg_q;
  assign div_by_zero = dbz_q;
endmodule
